apb_protocol: RTL and testbench
===============================

# apb_protocol

Self-contained APB subsystem. It contains an APB master FSM driven by a simple request interface, plus two APB slaves: a 16-word register RAM (slave 1) and a register block with an 8N1 UART receiver (slave 2). It is the top-level APB fabric of the design, and the bench drives it directly through request pins.

## Interface
- `CLKS_PER_BIT`, default 16: pclk cycles per UART bit on `rx`.
- `MEM_DEPTH`, default 16: words per slave; fixed power of two, indexed by address bits [5:2].
- `pclk`, input, 1: the single clock; all logic is rising-edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `penable`, input, 1: master enable; gates the SETUP→ACCESS advance.
- `pwrite`, input, 1: 1 = write, 0 = read; sampled on entering SETUP.
- `transfer`, input, 1: transfer request.
- `write_paddr`, input, 32: write byte address.
- `apb_read_paddr`, input, 32: read byte address.
- `write_data`, input, 32: write data.
- `Psel`, input, 2: slave select. 01 = slave 1, 10 = slave 2, 00/11 = none.
- `apb_read_data_out`, output, 32: last completed read data.
- `PSTRB`, output, 4: byte strobes of the current transfer.
- `rx`, input, 1: UART serial input, idles high.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when `transfer`=1 and `Psel` is 01 or 10. Otherwise stay in IDLE.
  - SETUP→ACCESS when `penable`=1. Otherwise hold in SETUP.
  - ACCESS with PREADY=0: hold.
  - ACCESS with PREADY=1: transfer completes. Go to SETUP if `transfer`=1 and `Psel` is valid, else IDLE.
- On entry to SETUP, latch the transfer fields:
  - address = `pwrite` ? `write_paddr` : `apb_read_paddr`
  - write flag, `write_data`, and the slave select
- Hold the latched values through ACCESS. Input changes mid-transfer affect only the next transfer.
- `PSTRB` = 4'b1111 in SETUP/ACCESS of a write, 4'b0000 otherwise. All writes are full-word.
- Word index = address[5:2]. All other address bits are ignored (0x00111111 → index 4).
- Slave 1:
  - 16×32 RAM, zero wait states (PREADY=1 in the first ACCESS cycle).
  - Reads return RAM[index].
- Slave 2:
  - One wait state: PREADY=0 in the first ACCESS cycle, 1 in the second.
  - Index 0–13: general RAM, read/write.
  - Index 14: RX_DATA, read-only = {24'b0, last received byte}. A completed read clears RX_VALID.
  - Index 15: RX_STATUS, read-only = {30'b0, overrun, rx_valid}. A completed read clears overrun.
  - Writes to 14/15 are ignored.
- UART receiver:
  - Start bit detected on a falling edge of `rx`, then confirmed at mid-bit. If `rx` is high at mid-bit, the start is false and the receiver returns to idle.
  - 8 data bits, LSB first, sampled at mid-bit every `CLKS_PER_BIT` cycles.
  - Stop bit must be 1; otherwise the frame is dropped.
  - A valid frame loads RX_DATA and sets rx_valid. If rx_valid was already 1, overrun is set.
- `apb_read_data_out` loads PRDATA on the completing ACCESS cycle of a read and holds otherwise. Writes leave it unchanged.
- Simultaneous UART frame completion and an RX_DATA read in the same cycle: the new byte wins, and rx_valid ends up 1.

## Timing
- Reset values:
  - FSM = IDLE, `PSTRB` = 0, `apb_read_data_out` = 0
  - all RAM words = 0, RX_DATA = 0, rx_valid = 0, overrun = 0
  - UART receiver idle
- Reset asserted mid-transfer aborts the transfer; no write commits.
- Write commit occurs on the completing ACCESS edge. Minimum latency from `transfer` to commit:
  - 3 edges for slave 1 (IDLE→SETUP, SETUP→ACCESS, ACCESS complete)
  - 4 edges for slave 2
- Read data is visible on `apb_read_data_out` the cycle after the completing edge.
- A read immediately following a write to the same address returns the new data.

## Structure
- Shared package `apb_protocol_pkg` holds:
  - state enum {IDLE, SETUP, ACCESS}
  - Psel codes SEL_S1 = 2'b01, SEL_S2 = 2'b10
  - register indices RX_DATA_IDX = 14, RX_STATUS_IDX = 15
- One sub-module, `uart_rx_8n1`, parameterized by `CLKS_PER_BIT`. Outputs: `data[7:0]`, `data_valid` pulse. It is instantiated inside slave 2.

## Test plan
- Reset, then read slave 1 index 0 → `apb_read_data_out` = 0x00000000, `PSTRB` = 0.
- Psel=10, transfer=1, penable=1, pwrite=1, write_data=0xDEAD2023, write_paddr=0x00111111; then pwrite=0, apb_read_paddr=0x00111111 → read returns 0xDEAD2023, `PSTRB` = 4'hF during the write. Repeat on Psel=01; slave 1 completes one cycle sooner.
- transfer=1 with penable=0 → FSM holds in SETUP and no write commits. Raise penable → write commits.
- Drive frame 0x5A on `rx` (16 clocks/bit) → RX_STATUS = 1, RX_DATA = 0x0000005A. A second RX_DATA read shows RX_STATUS = 0.
- Two frames with no read between them → RX_STATUS = 3, RX_DATA = second byte. Frame with stop bit = 0 → no update.
- Assert Reset during slave 2 ACCESS of a write of 0x12345678 → the location stays 0 and the FSM returns to IDLE.

Source files
------------

// File: rtl/apb_protocol_pkg.sv
// Shared types and constants for the APB master and its two slaves.
// Address decode uses word index bits [5:2]; RX registers sit at the top of slave 2.
package apb_protocol_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] SEL_S1 = 2'b01;
  localparam logic [1:0] SEL_S2 = 2'b10;

  localparam logic [3:0] RX_DATA_IDX   = 4'd14;
  localparam logic [3:0] RX_STATUS_IDX = 4'd15;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (sel == SEL_S1) || (sel == SEL_S2);
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, one-cycle data_valid pulse.
//  state   | meaning
//  U_IDLE  | line idle, waiting for a falling edge
//  U_START | counting to mid start bit to confirm it
//  U_DATA  | sampling 8 data bits LSB first
//  U_STOP  | sampling stop bit; frame dropped if low
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       pclk,
  input  logic       Reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid
);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} rx_state_e;

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e      state, state_nxt;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           tc;

  assign tc = (cnt == '0);

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      state   <= U_IDLE;
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      state   <= state_nxt;
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      U_IDLE:  if (rx_prev && !rx_sync) state_nxt = U_START;
      U_START: if (tc) state_nxt = rx_sync ? U_IDLE : U_DATA;
      U_DATA:  if (tc && (bit_cnt == 3'd7)) state_nxt = U_STOP;
      U_STOP:  if (tc) state_nxt = U_IDLE;
      default: state_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      cnt        <= HALF;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        U_IDLE: begin
          cnt     <= HALF;
          bit_cnt <= '0;
        end
        U_START: cnt <= tc ? FULL : cnt - 1'b1;
        U_DATA: begin
          if (tc) begin
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= FULL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        U_STOP: begin
          if (tc) begin
            if (rx_sync) begin
              data       <= shift;
              data_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: cnt <= HALF;
      endcase
    end
  end

endmodule

// File: rtl/apb_protocol.sv
// APB fabric: request-driven master FSM, zero-wait RAM slave and one-wait-state RAM/UART slave.
//  state  | meaning
//  IDLE   | no transfer in progress
//  SETUP  | fields latched, waiting for penable
//  ACCESS | slave selected; completes when pready is high
module apb_protocol
  import apb_protocol_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int MEM_DEPTH    = 16
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        penable,
  input  logic        pwrite,
  input  logic        transfer,
  input  logic [31:0] write_paddr,
  input  logic [31:0] apb_read_paddr,
  input  logic [31:0] write_data,
  input  logic [1:0]  Psel,
  output logic [31:0] apb_read_data_out,
  output logic [3:0]  PSTRB,
  input  logic        rx
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_RXD = IDX_W'(RX_DATA_IDX);
  localparam logic [IDX_W-1:0] IDX_RXS = IDX_W'(RX_STATUS_IDX);

  apb_state_e       state, state_nxt;
  logic [1:0]       sel_q;
  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             wait_done;
  logic             pready, complete, latch;
  logic [31:0]      prdata;

  logic [31:0]      ram1 [MEM_DEPTH];
  logic [31:0]      ram2 [MEM_DEPTH];
  logic [7:0]       rx_byte;
  logic             rx_valid, overrun;
  logic [7:0]       uart_data;
  logic             uart_valid;
  logic             rd_rx_data, rd_rx_status;

  assign pready   = (sel_q == SEL_S2) ? wait_done : 1'b1;
  assign complete = (state == ACCESS) && pready;
  assign latch    = (state_nxt == SETUP) && (state != SETUP);
  assign PSTRB    = ((state != IDLE) && write_q) ? 4'hF : 4'h0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer && sel_valid(Psel)) state_nxt = SETUP;
      SETUP:   if (penable) state_nxt = ACCESS;
      ACCESS:  if (pready) state_nxt = (transfer && sel_valid(Psel)) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wait_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_done <= (state == ACCESS) && (sel_q == SEL_S2) && !wait_done;
      if (latch) begin
        sel_q   <= Psel;
        write_q <= pwrite;
        idx_q   <= pwrite ? write_paddr[IDX_W+1:2] : apb_read_paddr[IDX_W+1:2];
        wdata_q <= write_data;
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (sel_q == SEL_S1)        prdata = ram1[idx_q];
    else if (idx_q == IDX_RXD)  prdata = {24'b0, rx_byte};
    else if (idx_q == IDX_RXS)  prdata = {30'b0, overrun, rx_valid};
    else                        prdata = ram2[idx_q];
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      apb_read_data_out <= '0;
    end else if (complete && !write_q) begin
      apb_read_data_out <= prdata;
    end
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        ram1[i] <= '0;
        ram2[i] <= '0;
      end
    end else if (complete && write_q) begin
      if (sel_q == SEL_S1)
        ram1[idx_q] <= wdata_q;
      else if ((sel_q == SEL_S2) && (idx_q < IDX_RXD))
        ram2[idx_q] <= wdata_q;
    end
  end

  assign rd_rx_data   = complete && !write_q && (sel_q == SEL_S2) && (idx_q == IDX_RXD);
  assign rd_rx_status = complete && !write_q && (sel_q == SEL_S2) && (idx_q == IDX_RXS);

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .pclk       (pclk),
    .Reset      (Reset),
    .rx         (rx),
    .data       (uart_data),
    .data_valid (uart_valid)
  );

  // A byte arriving in the same cycle as an RX_DATA read wins over the clear.
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rd_rx_data)   rx_valid <= 1'b0;
      if (rd_rx_status) overrun  <= 1'b0;
      if (uart_valid) begin
        rx_byte  <= uart_data;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_rx_data) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_protocol.sv
// Directed plus randomized bench for apb_protocol against a word-level model of both slaves.
module tb_apb_protocol;

  logic        pclk, Reset, penable, pwrite, transfer, rx;
  logic [31:0] write_paddr, apb_read_paddr, write_data, apb_read_data_out;
  logic [1:0]  Psel;
  logic [3:0]  PSTRB;

  int          n_cmp, n_err;
  logic [31:0] m1 [16];
  logic [31:0] m2 [16];
  logic [7:0]  m_rxb;
  logic        m_valid, m_ovr;
  logic [31:0] exp_out;

  apb_protocol #(.CLKS_PER_BIT(16), .MEM_DEPTH(16)) dut (
    .pclk              (pclk),
    .Reset             (Reset),
    .penable           (penable),
    .pwrite            (pwrite),
    .transfer          (transfer),
    .write_paddr       (write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .write_data        (write_data),
    .Psel              (Psel),
    .apb_read_data_out (apb_read_data_out),
    .PSTRB             (PSTRB),
    .rx                (rx)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m1[i] = '0;
      m2[i] = '0;
    end
    m_rxb   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    exp_out = '0;
  endtask

  task automatic model_access(input logic [1:0] sel, input logic wr, input logic [3:0] idx,
                              input logic [31:0] wd, output logic [31:0] rd);
    rd = '0;
    if (sel == 2'b01) begin
      if (wr) m1[idx] = wd;
      else    rd = m1[idx];
    end else if (idx < 4'd14) begin
      if (wr) m2[idx] = wd;
      else    rd = m2[idx];
    end else if (!wr) begin
      if (idx == 4'd14) begin
        rd = {24'b0, m_rxb};
        m_valid = 1'b0;
      end else begin
        rd = {30'b0, m_ovr, m_valid};
        m_ovr = 1'b0;
      end
    end
  endtask

  // One transfer; the expected latency (3 edges for slave 1, 4 for slave 2) is built in.
  task automatic xfer(input logic [1:0] sel, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    @(negedge pclk);
    transfer       = 1'b1;
    penable        = 1'b1;
    Psel           = sel;
    pwrite         = wr;
    write_paddr    = wr ? addr : $urandom;
    apb_read_paddr = wr ? $urandom : addr;
    write_data     = wd;
    @(posedge pclk);
    @(negedge pclk);
    transfer       = 1'b0;
    pwrite         = $urandom_range(0, 1);
    Psel           = 2'($urandom_range(0, 3));
    write_paddr    = $urandom;
    apb_read_paddr = $urandom;
    write_data     = $urandom;
    chk("pstrb_setup", {28'b0, PSTRB}, wr ? 32'hF : 32'h0);
    @(posedge pclk);
    @(negedge pclk);
    chk("pstrb_access", {28'b0, PSTRB}, wr ? 32'hF : 32'h0);
    if (sel == 2'b10) begin
      @(posedge pclk);
      @(negedge pclk);
      chk("wait_state_hold", apb_read_data_out, exp_out);
    end
    @(posedge pclk);
    @(negedge pclk);
    model_access(sel, wr, addr[5:2], wd, rd);
    if (!wr) exp_out = rd;
    chk(wr ? "write_keeps_rdata" : "read_data", apb_read_data_out, exp_out);
    chk("pstrb_done", {28'b0, PSTRB}, 32'h0);
  endtask

  task automatic bad_sel_req(input logic [1:0] sel);
    @(negedge pclk);
    transfer    = 1'b1;
    penable     = 1'b1;
    Psel        = sel;
    pwrite      = 1'b1;
    write_paddr = $urandom;
    write_data  = $urandom;
    @(posedge pclk);
    @(negedge pclk);
    chk("no_sel_pstrb", {28'b0, PSTRB}, 32'h0);
    transfer = 1'b0;
    repeat (2) @(posedge pclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge pclk);
    rx = 1'b0;
    repeat (16) @(negedge pclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge pclk);
    end
    rx = stop;
    repeat (16) @(negedge pclk);
    rx = 1'b1;
    repeat (8) @(negedge pclk);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_rxb   = b;
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_addr(input logic [3:0] idx);
    logic [31:0] a;
    a      = $urandom;
    a[5:2] = idx;
    return a;
  endfunction

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    Reset          = 1'b1;
    rx             = 1'b1;
    transfer       = 1'b0;
    penable        = 1'b0;
    pwrite         = 1'b0;
    Psel           = 2'b00;
    write_paddr    = '0;
    apb_read_paddr = '0;
    write_data     = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    Reset = 1'b0;
    @(negedge pclk);
    chk("reset_rdata", apb_read_data_out, 32'h0);
    chk("reset_pstrb", {28'b0, PSTRB}, 32'h0);

    xfer(2'b01, 1'b0, 32'h0000_0000, 32'h0);
    xfer(2'b10, 1'b1, 32'h0011_1111, 32'hDEAD_2023);
    xfer(2'b10, 1'b0, 32'h0011_1111, 32'h0);
    chk("s2_idx4_value", apb_read_data_out, 32'hDEAD_2023);
    xfer(2'b01, 1'b1, 32'h0011_1111, 32'hCAFE_0001);
    xfer(2'b01, 1'b0, 32'h0011_1111, 32'h0);
    chk("s1_idx4_value", apb_read_data_out, 32'hCAFE_0001);
    xfer(2'b10, 1'b0, 32'hFFFF_FF10, 32'h0);

    // penable low: FSM must sit in SETUP with the write pending
    @(negedge pclk);
    transfer    = 1'b1;
    penable     = 1'b0;
    Psel        = 2'b01;
    pwrite      = 1'b1;
    write_paddr = 32'h0000_000C;
    write_data  = 32'hA5A5_0003;
    @(posedge pclk);
    @(negedge pclk);
    transfer = 1'b0;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    chk("penable_hold_pstrb", {28'b0, PSTRB}, 32'hF);
    penable = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("penable_done_pstrb", {28'b0, PSTRB}, 32'h0);
    m1[3] = 32'hA5A5_0003;
    xfer(2'b01, 1'b0, 32'h0000_000C, 32'h0);
    chk("penable_commit", apb_read_data_out, 32'hA5A5_0003);

    bad_sel_req(2'b00);
    bad_sel_req(2'b11);

    send_byte(8'h5A, 1'b1);
    xfer(2'b10, 1'b0, rand_addr(4'd15), 32'h0);
    chk("rx_status_one", apb_read_data_out, 32'h1);
    xfer(2'b10, 1'b0, rand_addr(4'd14), 32'h0);
    chk("rx_data_5a", apb_read_data_out, 32'h5A);
    xfer(2'b10, 1'b0, rand_addr(4'd15), 32'h0);
    chk("rx_status_cleared", apb_read_data_out, 32'h0);

    send_byte(8'h11, 1'b1);
    send_byte(8'hC3, 1'b1);
    xfer(2'b10, 1'b0, rand_addr(4'd15), 32'h0);
    chk("rx_status_overrun", apb_read_data_out, 32'h3);
    xfer(2'b10, 1'b0, rand_addr(4'd14), 32'h0);
    chk("rx_data_second", apb_read_data_out, 32'hC3);
    send_byte(8'h77, 1'b0);
    xfer(2'b10, 1'b0, rand_addr(4'd14), 32'h0);
    chk("rx_bad_stop", apb_read_data_out, 32'hC3);
    xfer(2'b10, 1'b1, rand_addr(4'd14), 32'hFFFF_FFFF);
    xfer(2'b10, 1'b0, rand_addr(4'd15), 32'h0);

    // Reset during the wait-state cycle of a slave 2 write
    @(negedge pclk);
    transfer    = 1'b1;
    penable     = 1'b1;
    Psel        = 2'b10;
    pwrite      = 1'b1;
    write_paddr = 32'h0000_0008;
    write_data  = 32'h1234_5678;
    @(posedge pclk);
    @(negedge pclk);
    transfer = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    Reset = 1'b1;
    model_reset();
    @(negedge pclk);
    Reset = 1'b0;
    chk("reset_mid_pstrb", {28'b0, PSTRB}, 32'h0);
    chk("reset_mid_rdata", apb_read_data_out, 32'h0);
    xfer(2'b10, 1'b0, 32'h0000_0008, 32'h0);
    chk("reset_no_commit", apb_read_data_out, 32'h0);

    for (int k = 0; k < 60; k++) begin
      int          op;
      logic [1:0]  sel;
      logic [3:0]  idx;
      op  = $urandom_range(0, 9);
      sel = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      idx = 4'($urandom_range(0, 15));
      if (op == 0)
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      else if (op == 1)
        bad_sel_req(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
      else
        xfer(sel, op < 5, rand_addr(idx), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
